// File: rtl/risc_int_pkg.sv
// risc_int_pkg: shared state type, default sizing and id-width helper for int_controller.
package risc_int_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    localparam int N_IRQ_DEF = 8;
    localparam int TIMEOUT_DEF = 16;
    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/int_controller_if.sv
// int_controller_if: request/mask/handshake bundle between int_controller (master) and the core side (slave).
// INT_TIMEOUT_EN adds timeout_err.
interface int_controller_if
    import risc_int_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W = id_w(N_IRQ)
) ();
    logic [N_IRQ-1:0] irq;
    logic mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic int_ack;
    logic eoi;
    logic INT;
    logic [ID_W-1:0] int_id;
    logic [N_IRQ-1:0] mask_out;
    logic [N_IRQ-1:0] pending_out;
    logic busy;
`ifdef INT_TIMEOUT_EN
    logic timeout_err;
    modport master (input irq, mask_we, mask_wdata, int_ack, eoi,
                    output INT, int_id, mask_out, pending_out, busy, timeout_err);
    modport slave (output irq, mask_we, mask_wdata, int_ack, eoi,
                   input INT, int_id, mask_out, pending_out, busy, timeout_err);
`else
    modport master (input irq, mask_we, mask_wdata, int_ack, eoi,
                    output INT, int_id, mask_out, pending_out, busy);
    modport slave (output irq, mask_we, mask_wdata, int_ack, eoi,
                   input INT, int_id, mask_out, pending_out, busy);
`endif
endinterface

// File: rtl/int_prio_enc.sv
// int_prio_enc: combinational lowest-index-wins priority encoder.
module int_prio_enc
    import risc_int_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W = id_w(N_IRQ)
) (
    input  logic [N_IRQ-1:0] eligible,
    output logic [ID_W-1:0]  id,
    output logic             valid
);
    always_comb begin
        id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) id = eligible[i] ? ID_W'(i) : id;
    end
    assign valid = |eligible;
endmodule

// File: rtl/int_controller.sv
// int_controller: edge-detecting, maskable, fixed-priority interrupt source driving the core's INT handshake.
// INT_TIMEOUT_EN adds an unacknowledged-INT timeout that returns to IDLE and pulses timeout_err.
module int_controller
    import risc_int_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF
`ifdef INT_TIMEOUT_EN
    , parameter int TIMEOUT = TIMEOUT_DEF
`endif
) (
    input logic clk,
    input logic rst,
    int_controller_if.master bus
);
    localparam int ID_W = id_w(N_IRQ);
    state_t state, state_n;
    logic [N_IRQ-1:0] irq_q, pending, pending_n, mask, mask_n, clr;
    logic [ID_W-1:0] int_id, int_id_n, enc_id;
    logic enc_valid;
`ifdef INT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic timeout_err, timeout_err_n;
`endif

    int_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_enc (
        .eligible(pending & ~mask),
        .id(enc_id),
        .valid(enc_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            irq_q <= '0;
            pending <= '0;
            mask <= '0;
            int_id <= '0;
`ifdef INT_TIMEOUT_EN
            cnt <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            state <= state_n;
            irq_q <= bus.irq;
            pending <= pending_n;
            mask <= mask_n;
            int_id <= int_id_n;
`ifdef INT_TIMEOUT_EN
            cnt <= cnt_n;
            timeout_err <= timeout_err_n;
`endif
        end
    end

    // A new edge is OR-ed in after the ack clear, so set wins on collision.
    always_comb begin
        state_n = state;
        int_id_n = int_id;
        clr = '0;
        mask_n = bus.mask_we ? bus.mask_wdata : mask;
`ifdef INT_TIMEOUT_EN
        cnt_n = '0;
        timeout_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                state_n = enc_valid ? REQ : IDLE;
                int_id_n = enc_valid ? enc_id : int_id;
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_n = SERVICE;
                    clr = N_IRQ'(1) << int_id;
                end
`ifdef INT_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    timeout_err_n = 1'b1;
                end else cnt_n = cnt + 1'b1;
`endif
            end
            SERVICE: state_n = bus.eoi ? IDLE : SERVICE;
            default: state_n = IDLE;
        endcase
        pending_n = (pending & ~clr) | (bus.irq & ~irq_q);
    end

    assign bus.INT = state == REQ;
    assign bus.busy = state != IDLE;
    assign bus.int_id = int_id;
    assign bus.mask_out = mask;
    assign bus.pending_out = pending;
`ifdef INT_TIMEOUT_EN
    assign bus.timeout_err = timeout_err;
`endif
endmodule
